// File: rtl/dist_mem_dp.sv
// Dual-port distributed memory: one write port (A), asynchronous read on A,
// registered read on B. After reset a CLEAR sequence walks every address and
// writes zero; writes from port A are blocked (and flagged in werr) while it runs.
//
// Configuration macro: DIST_MEM_BYPASS_EN
//   defined   -> port B is write-first on an A-write/B-read address collision
//   undefined -> port B is read-first (captures the old word)
//
// Handshake: there is no valid/ready pair. busy=1 means the clear sequence owns
//   the write port and any we=1 is discarded (werr latches); busy=0 means every
//   edge with we=1 commits d to mem[a].
module dist_mem_dp #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  spo,
  input  logic [ADDR_W-1:0] dpra,
  output logic [WIDTH-1:0]  dpo,
  output logic              busy,
  output logic              werr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] clr_addr;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_en;
  logic [WIDTH-1:0]  dpo_next;

  // Next-state and busy decode; the last clear write hands over to READY.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      CLEAR: begin
        busy = 1'b1;
        if (&clr_addr) next_state = READY;
      end
      READY: next_state = READY;
      default: next_state = CLEAR;
    endcase
  end

  assign wr_en = we & ~busy;

  // Port B next value: collision resolution depends on the bypass build option.
  always_comb begin
    dpo_next = mem[dpra];
`ifdef DIST_MEM_BYPASS_EN
    if (wr_en && (a == dpra)) dpo_next = d;
`endif
  end

  // Control state, clear counter, sticky write-error flag and port B register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      werr     <= 1'b0;
      dpo      <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (busy && we) werr <= 1'b1;
      dpo <= dpo_next;
    end
  end

  // Storage: the clear sequence has priority; contents are never reset directly.
  always_ff @(posedge clk) begin
    if (busy) mem[clr_addr] <= '0;
    else if (wr_en) mem[a] <= d;
  end

  // Port A asynchronous read, live even during the clear sequence.
  assign spo = mem[a];

endmodule

// File: tb/tb_dist_mem_dp.sv
// Bench for dist_mem_dp (WIDTH=8, ADDR_W=4): directed scenarios followed by
// random traffic, checked against an array model through two expectation queues.
module tb_dist_mem_dp;

  localparam int W = 8;
  localparam int AW = 4;
  localparam int N = 16;

  typedef struct {
    logic [W-1:0] val;
    logic         care;
  } spo_exp_t;

  typedef struct {
    logic [W-1:0] dpo;
    logic         care;
    logic         busy;
    logic         werr;
  } out_exp_t;

  // clock / reset
  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] a;
  logic [W-1:0]  d;
  logic [W-1:0]  spo;
  logic [AW-1:0] dpra;
  logic [W-1:0]  dpo;
  logic          busy;
  logic          werr;

  always #5 clk = ~clk;

  dist_mem_dp #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .a(a), .d(d), .spo(spo),
    .dpra(dpra), .dpo(dpo), .busy(busy), .werr(werr)
  );

  // reference model: contents, which words are defined, clear progress
  logic [W-1:0]  m_mem [N];
  logic          m_known [N];
  logic          m_busy;
  logic [AW-1:0] m_clr;
  logic          m_werr;

  spo_exp_t spo_q[$];
  out_exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at a falling edge; drives one cycle and advances the model
  task automatic cycle(input logic w, input logic [AW-1:0] aa, input logic [W-1:0] dd,
                       input logic [AW-1:0] ra);
    out_exp_t e;
    logic wr;
    we = w; a = aa; d = dd; dpra = ra;
    spo_q.push_back('{val: m_mem[aa], care: m_known[aa]});
    @(posedge clk);
    wr = w && !m_busy;
    e.dpo  = m_mem[ra];
    e.care = m_known[ra];
`ifdef DIST_MEM_BYPASS_EN
    if (wr && aa == ra) begin
      e.dpo  = dd;
      e.care = 1'b1;
    end
`endif
    if (m_busy && w) m_werr = 1'b1;
    if (m_busy) begin
      m_mem[m_clr]   = '0;
      m_known[m_clr] = 1'b1;
      if (m_clr == AW'(N - 1)) m_busy = 1'b0;
      m_clr = m_clr + 1'b1;
    end else if (wr) begin
      m_mem[aa]   = dd;
      m_known[aa] = 1'b1;
    end
    e.busy = m_busy;
    e.werr = m_werr;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // asynchronous reset pulse in the low phase; returns at a falling edge
  task automatic pulse_rst(input int hold);
    we = 1'b0;
    #3 rst = 1'b1;
    m_busy = 1'b1; m_clr = '0; m_werr = 1'b0;
    #1;
    chk("rst_busy", W'(busy), W'(1));
    chk("rst_werr", W'(werr), W'(0));
    chk("rst_dpo", dpo, '0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor: port A read after inputs settle
  always @(negedge clk) begin
    #2;
    if (spo_q.size() > 0) begin
      spo_exp_t s;
      s = spo_q.pop_front();
      if (s.care) chk("spo", spo, s.val);
    end
  end

  // monitor: registered outputs after each rising edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      out_exp_t e;
      e = exp_q.pop_front();
      if (e.care) chk("dpo", dpo, e.dpo);
      chk("busy", W'(busy), W'(e.busy));
      chk("werr", W'(werr), W'(e.werr));
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int busy_edges;
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b0;
    end
    rst = 1'b1; we = 1'b0; a = '0; d = '0; dpra = '0;
    m_busy = 1'b1; m_clr = '0; m_werr = 1'b0;
    @(negedge clk);
    #1;
    chk("init_busy", W'(busy), W'(1));
    chk("init_werr", W'(werr), W'(0));
    chk("init_dpo", dpo, '0);
    @(negedge clk);
    rst = 1'b0;

    // clear lasts exactly N edges; a write attempt at address 3 mid-clear
    busy_edges = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 5) cycle(1'b1, 4'd3, 8'h3C, 4'd0);
      else cycle(1'b0, AW'(i), '0, AW'(i));
      if (busy) busy_edges++;
    end
    chk("clear_len", W'(busy_edges), W'(N - 1));

    // every address reads zero on both ports; werr remains set
    for (int i = 0; i < N; i++) cycle(1'b0, AW'(i), '0, AW'(i));
    cycle(1'b0, 4'd3, '0, 4'd3);

    // simple writes and readback
    cycle(1'b1, 4'd0, 8'd0, 4'd9);
    cycle(1'b1, 4'd1, 8'd1, 4'd9);
    cycle(1'b1, 4'd2, 8'd2, 4'd9);
    cycle(1'b0, 4'd0, '0, 4'd2);
    cycle(1'b0, 4'd1, '0, 4'd2);
    cycle(1'b0, 4'd2, '0, 4'd2);

    // collision on address 5
    cycle(1'b1, 4'd5, 8'hA5, 4'd5);
    cycle(1'b0, 4'd5, '0, 4'd5);

    // write top address, reset mid-clear at clear address 7
    cycle(1'b1, 4'd15, 8'hFF, 4'd15);
    cycle(1'b0, 4'd15, '0, 4'd15);
    pulse_rst(2);
    for (int i = 0; i < 7; i++) cycle(1'b0, 4'd15, '0, 4'd15);
    pulse_rst(1);
    busy_edges = 0;
    for (int i = 0; i < N; i++) begin
      cycle(1'b0, 4'd15, '0, 4'd15);
      if (busy) busy_edges++;
    end
    chk("reclear_len", W'(busy_edges), W'(N - 1));
    cycle(1'b0, 4'd15, '0, 4'd15);
    cycle(1'b0, 4'd15, '0, 4'd15);

    // random traffic, biased towards collisions
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] ra, rb;
      ra = AW'($urandom_range(0, N - 1));
      rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, N - 1));
      cycle(1'($urandom_range(0, 1)), ra, W'($urandom_range(0, 255)), rb);
    end

    // a few random writes attempted during another clear
    pulse_rst(1);
    for (int i = 0; i < N + 8; i++)
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)),
            W'($urandom_range(0, 255)), AW'($urandom_range(0, N - 1)));

    // drain
    repeat (3) @(negedge clk);
    checks++;
    if (spo_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: queues hold %0d/%0d entries, expected 0/0", spo_q.size(), exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dist_mem_dp.md
DIST_MEM_DP -- requirements
Module: dist_mem_dp

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 8, data word width in bits (>=1).
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable for port A.
- a  input  ADDR_W  port A address (write and async read).
- d  input  WIDTH  port A write data.
- spo  output  WIDTH  port A asynchronous read data.
- dpra  input  ADDR_W  port B read address.
- dpo  output  WIDTH  port B registered read data.
- busy  output  1  high while post-reset clear sequence runs.
- werr  output  1  sticky flag: write attempted while busy.

Function
REQ-003 Storage SHALL be DEPTH words of WIDTH bits, one write port (A) and two read ports (A, B).
REQ-004 spo SHALL equal mem[a] combinationally at all times, including during clear, with zero-cycle latency.
REQ-005 A write SHALL occur at the rising edge of clk when we=1 and busy=0: mem[a] <= d; spo reflects new data after that edge.
REQ-006 dpo SHALL be registered: at each rising edge dpo <= mem[dpra], one-cycle latency; port B is readable during clear.
REQ-007 FSM SHALL have two states: CLEAR and READY.
REQ-008 In CLEAR, an ADDR_W-bit counter clr_addr SHALL write zero to mem[clr_addr] each edge and increment; on the edge that clears address DEPTH-1 the FSM SHALL go to READY.
REQ-009 busy SHALL be 1 in CLEAR and 0 in READY; clear completes exactly DEPTH edges after rst deasserts.
REQ-010 While busy=1, we=1 SHALL NOT modify memory and SHALL set werr=1 at that edge; werr stays 1 until rst.
REQ-011 READY SHALL persist until rst; no other transition exists.
REQ-012 Simultaneous write to address X and dpra=X: dpo behaviour SHALL follow REQ-018.
REQ-013 Address wrap: a, dpra, clr_addr are modulo DEPTH; no out-of-range state exists.

Reset
REQ-014 Asserting rst SHALL immediately (asynchronously) set state=CLEAR, clr_addr=0, busy=1, werr=0, dpo=0.
REQ-015 Memory contents SHALL NOT be reset asynchronously; they become zero via the clear sequence.
REQ-016 rst asserted mid-clear SHALL restart clear from address 0 with full DEPTH-cycle duration.

Configuration
REQ-017 Macro DIST_MEM_BYPASS_EN SHALL select port-B write/read collision behaviour.
REQ-018 Defined: when a write (REQ-005) to X coincides with dpra=X, dpo SHALL capture d (write-first). Undefined: dpo SHALL capture the old mem[X] (read-first). spo is unaffected by the macro.

Verification (WIDTH=8, ADDR_W=4)
REQ-019 Release rst -> busy=1 for exactly 16 edges, then 0; spo and dpo read 0 at all 16 addresses.
REQ-020 After clear, write (a,d)=(0,0),(1,1),(2,2) with we=1, then we=0 and a=0,1,2 -> spo=0,1,2 immediately; dpra=2 -> dpo=2 one edge later.
REQ-021 Write a=5,d=8'hA5 while dpra=5 (old 8'h00) -> dpo=8'hA5 with DIST_MEM_BYPASS_EN, 8'h00 without; next edge 8'hA5 both.
REQ-022 we=1,a=3,d=8'h3C during clear -> mem[3] stays 0, werr=1 and holds after busy falls.
REQ-023 Write 8'hFF to address 15, pulse rst at clear address 7 -> busy restarts, stays 1 for 16 edges after release, mem[15]=0 afterward, werr=0.
